// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder with valid/ready flow control, a one-entry skid buffer
// and a saturating illegal-instruction counter.
package cpu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } t_alu_op;
   typedef struct packed {
      t_alu_op    alu_op;
      logic       sel_alu_pc;
      logic       sel_alu_imm;
      logic       sel_dmem_wb;
      logic       sel_next_pc_alu_out;
      logic       reg_wr_en;
      logic [3:0] mem_byt_en;
      logic       mem_wr_en;
      logic       sel_wb;
   } t_ctrl;
   localparam t_ctrl CTRL_DEFAULT = '{ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
endpackage

module decode_stage import cpu_pkg::*; #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [XLEN-1:0]  imm,
   output t_ctrl            ctrl,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      t_ctrl           ctrl;
      logic            illegal;
   } t_ent;

   t_ent             dec, out_q, out_d, skid_q, skid_d;
   logic             out_v_q, out_v_d, skid_v_q, skid_v_d, acc, load_out;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       opc, f7;
   logic [2:0]       f3;
   logic [3:0]       byt;
   t_alu_op          r_op;

   always_comb begin
      opc  = in_instr[6:0];
      f3   = in_instr[14:12];
      f7   = in_instr[31:25];
      byt  = f3[1:0] == 2'd0 ? 4'b0001 : f3[1:0] == 2'd1 ? 4'b0011 : 4'b1111;
      // opc[5] separates OP from OP-IMM, which has no SUB
      case (f3)
         3'd0:    r_op = (opc[5] & in_instr[30]) ? ALU_SUB : ALU_ADD;
         3'd1:    r_op = ALU_SLL;
         3'd2:    r_op = ALU_SLT;
         3'd3:    r_op = ALU_SLTU;
         3'd4:    r_op = ALU_XOR;
         3'd5:    r_op = in_instr[30] ? ALU_SRA : ALU_SRL;
         3'd6:    r_op = ALU_OR;
         default: r_op = ALU_AND;
      endcase
      dec.pc      = in_pc;
      dec.rs1     = in_instr[19:15];
      dec.rs2     = in_instr[24:20];
      dec.rd      = in_instr[11:7];
      dec.imm     = '0;
      dec.ctrl    = CTRL_DEFAULT;
      dec.illegal = 1'b0;
      case (opc)
         7'b0110011: begin
            dec.ctrl.reg_wr_en = 1'b1;
            dec.ctrl.alu_op    = r_op;
            dec.illegal        = !(f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)));
         end
         7'b0010011: begin
            dec.imm              = XLEN'($signed(in_instr[31:20]));
            dec.ctrl.reg_wr_en   = 1'b1;
            dec.ctrl.sel_alu_imm = 1'b1;
            dec.ctrl.alu_op      = r_op;
            dec.illegal          = (f3 == 3'd1 && f7 != 7'd0) ||
                                   (f3 == 3'd5 && (f7 & 7'b1011111) != 7'd0);
         end
         7'b0000011: begin
            dec.imm              = XLEN'($signed(in_instr[31:20]));
            dec.ctrl.sel_alu_imm = 1'b1;
            dec.ctrl.reg_wr_en   = 1'b1;
            dec.ctrl.sel_dmem_wb = 1'b1;
            dec.ctrl.mem_byt_en  = byt;
            dec.illegal          = f3 inside {3'd3, 3'd6, 3'd7};
         end
         7'b0100011: begin
            dec.imm              = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            dec.ctrl.sel_alu_imm = 1'b1;
            dec.ctrl.mem_wr_en   = 1'b1;
            dec.ctrl.mem_byt_en  = byt;
            dec.illegal          = f3 >= 3'd3;
         end
         7'b1100011: begin
            dec.imm              = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
            dec.ctrl.sel_alu_pc  = 1'b1;
            dec.ctrl.sel_alu_imm = 1'b1;
            dec.illegal          = f3 inside {3'd2, 3'd3};
         end
         7'b1101111, 7'b1100111: begin
            dec.imm                      = opc[3] ?
               XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0})) :
               XLEN'($signed(in_instr[31:20]));
            dec.ctrl.sel_alu_pc          = opc[3];
            dec.ctrl.sel_alu_imm         = 1'b1;
            dec.ctrl.sel_next_pc_alu_out = 1'b1;
            dec.ctrl.reg_wr_en           = 1'b1;
            dec.ctrl.sel_wb              = 1'b0;
         end
         7'b0110111, 7'b0010111: begin
            dec.imm              = XLEN'($signed({in_instr[31:12], 12'b0}));
            dec.rs1              = opc[5] ? 5'd0 : in_instr[19:15];
            dec.ctrl.sel_alu_pc  = ~opc[5];
            dec.ctrl.sel_alu_imm = 1'b1;
            dec.ctrl.reg_wr_en   = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      if (dec.illegal) dec.ctrl = CTRL_DEFAULT;
   end

   always_comb begin
      in_ready = ~skid_v_q;
      acc      = in_valid & in_ready & ~flush;
      load_out = ~out_v_q | out_ready;
      out_v_d  = ~flush & (load_out ? (skid_v_q | acc) : 1'b1);
      skid_v_d = ~flush & ~load_out & (skid_v_q | acc);
      out_d    = (load_out & skid_v_q) ? skid_q : (load_out & acc) ? dec : out_q;
      skid_d   = (~load_out & acc) ? dec : skid_q;
      cnt_d    = cnt_q + CNT_W'(acc & dec.illegal & ~&cnt_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_v_q  <= 1'b0;
         skid_v_q <= 1'b0;
         out_q    <= '0;
         skid_q   <= '0;
         cnt_q    <= '0;
      end else begin
         out_v_q  <= out_v_d;
         skid_v_q <= skid_v_d;
         out_q    <= out_d;
         skid_q   <= skid_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid   = out_v_q;
   assign out_pc      = out_q.pc;
   assign rs1         = out_q.rs1;
   assign rs2         = out_q.rs2;
   assign rd          = out_q.rd;
   assign imm         = out_q.imm;
   assign ctrl        = out_q.ctrl;
   assign illegal     = out_q.illegal;
   assign illegal_cnt = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench; expected entries are queued at accept and checked by a monitor.
module tb_decode_stage;
   import cpu_pkg::*;

   logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
   logic [31:0] in_instr = 0, in_pc = 0;
   logic        in_ready, out_valid, illegal;
   logic [31:0] out_pc, imm;
   logic [4:0]  rs1, rs2, rd;
   t_ctrl       ctrl;
   logic [7:0]  illegal_cnt;
   logic        in_ready2, out_valid2, illegal2;
   logic [31:0] out_pc2, imm2;
   logic [4:0]  rs1_2, rs2_2, rd_2;
   t_ctrl       ctrl2;
   logic [1:0]  cnt2;

   decode_stage #(.XLEN(32), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .ctrl(ctrl),
      .illegal(illegal), .illegal_cnt(illegal_cnt));

   decode_stage #(.XLEN(32), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid2), .out_ready(out_ready),
      .out_pc(out_pc2), .rs1(rs1_2), .rs2(rs2_2), .rd(rd_2), .imm(imm2), .ctrl(ctrl2),
      .illegal(illegal2), .illegal_cnt(cnt2));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      t_ctrl       ctrl;
      logic        illegal;
   } t_exp;

   t_exp       q[$];
   int         errors = 0, checks = 0, cnt_m = 0;
   bit         rst_prev = 0, rnd = 0;
   logic [6:0] opcs [0:8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic t_ctrl ctrl_def();
      t_ctrl c = '0;
      c.sel_wb = 1'b1;
      return c;
   endfunction

   function automatic t_exp decode_model(input logic [31:0] i, input logic [31:0] pc);
      t_exp        e;
      t_ctrl       c = ctrl_def();
      logic [2:0]  f3 = i[14:12];
      logic [6:0]  f7 = i[31:25];
      logic [31:0] si = $signed(i) >>> 20;
      t_alu_op     tab [0:7] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      bit          bad = 0;
      e.pc = pc; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.imm = 0;
      case (i[6:0])
         7'h33: begin
            c.reg_wr_en = 1;
            c.alu_op = f7 == 7'h20 ? (f3 == 0 ? ALU_SUB : ALU_SRA) : tab[f3];
            bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
         end
         7'h13: begin
            e.imm = si; c.reg_wr_en = 1; c.sel_alu_imm = 1;
            c.alu_op = (f3 == 5 && i[30]) ? ALU_SRA : tab[f3];
            bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
         end
         7'h03: begin
            e.imm = si; c.sel_alu_imm = 1; c.reg_wr_en = 1; c.sel_dmem_wb = 1;
            c.mem_byt_en = 4'((1 << (1 << f3[1:0])) - 1);
            bad = (f3 == 3 || f3 == 6 || f3 == 7);
         end
         7'h23: begin
            e.imm = {si[31:5], i[11:7]}; c.sel_alu_imm = 1; c.mem_wr_en = 1;
            c.mem_byt_en = 4'((1 << (1 << f3[1:0])) - 1);
            bad = f3 >= 3;
         end
         7'h63: begin
            e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            c.sel_alu_pc = 1; c.sel_alu_imm = 1;
            bad = (f3 == 2 || f3 == 3);
         end
         7'h6F, 7'h67: begin
            e.imm = i[3] ? {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0} : si;
            c.sel_alu_pc = i[3]; c.sel_alu_imm = 1; c.sel_next_pc_alu_out = 1;
            c.reg_wr_en = 1; c.sel_wb = 0;
         end
         7'h37: begin e.imm = i & 32'hFFFFF000; e.rs1 = 0; c.sel_alu_imm = 1; c.reg_wr_en = 1; end
         7'h17: begin e.imm = i & 32'hFFFFF000; c.sel_alu_pc = 1; c.sel_alu_imm = 1; c.reg_wr_en = 1; end
         default: bad = 1;
      endcase
      e.ctrl = bad ? ctrl_def() : c;
      e.illegal = bad;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      logic [6:0]  f7;
      int          s = $urandom_range(0, 3);
      f7 = s < 2 ? 7'h00 : s == 2 ? 7'h20 : r[31:25];
      if ($urandom_range(0, 7) == 0) return r;
      return {f7, r[24:7], opcs[$urandom_range(0, 8)]};
   endfunction

   initial forever begin
      t_exp e;
      @(negedge clk);
      if (!rst_n) begin
         q.delete();
         cnt_m = 0;
         rst_prev = 1;
      end else begin
         if (rst_prev) chk("reset_payload", {out_pc, rs1, rs2, rd, imm, ctrl, illegal}, 0);
         rst_prev = 0;
         chk("out_valid", out_valid, q.size() > 0);
         chk("in_ready", in_ready, q.size() < 2);
         chk("illegal_cnt", illegal_cnt, cnt_m);
         chk("illegal_cnt_w2", cnt2, cnt_m > 3 ? 3 : cnt_m);
         if (out_valid && q.size() > 0) chk("payload", {out_pc, rs1, rs2, rd, imm, ctrl, illegal}, q[0]);
         if (flush) q.delete();
         else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
               e = decode_model(in_instr, in_pc);
               q.push_back(e);
               if (e.illegal && cnt_m < 255) cnt_m++;
            end
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (rnd) begin
         out_ready = $urandom_range(0, 3) != 0;
         flush = $urandom_range(0, 40) == 0;
      end
   end

   task automatic cycle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] pc);
      logic r;
      in_instr = ins; in_pc = pc; in_valid = 1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk); r = in_ready;
         @(posedge clk); #1;
         if (r) begin in_valid = 0; return; end
      end
      errors++; checks++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
      in_valid = 0;
   endtask

   initial begin
      cycle(2); rst_n = 1; out_ready = 1;
      send(32'hFFF00093, 32'h100);
      chk("addi_imm", imm, 32'hFFFFFFFF);
      chk("addi_ctrl", {out_valid, rd, ctrl.sel_alu_imm, ctrl.reg_wr_en, ctrl.alu_op}, {1'b1, 5'd1, 1'b1, 1'b1, ALU_ADD});
      send(32'h402081B3, 32'h104);
      chk("sub_op", ctrl.alu_op, ALU_SUB);
      send(32'h0020A423, 32'h108);
      chk("sw", {imm, ctrl.mem_wr_en, ctrl.mem_byt_en, ctrl.reg_wr_en, illegal}, {32'd8, 1'b1, 4'b1111, 1'b0, 1'b0});
      cycle(2); out_ready = 0;
      fork
         begin send(32'h00100093, 32'h200); send(32'h00200113, 32'h204); send(32'h00300193, 32'h208); end
         begin cycle(4); chk("bp_in_ready", in_ready, 0); chk("bp_out_pc", out_pc, 32'h200); out_ready = 1; end
      join
      cycle(3);
      repeat (3) send(32'h0, 32'h300);
      send(32'hFFFFFFFF, 32'h30C);
      chk("ill_flag_ctrl", {illegal, ctrl}, {1'b1, ctrl_def()});
      chk("ill_cnt4", illegal_cnt, 4);
      chk("ill_cnt_sat2", cnt2, 3);
      send(32'h001000EF, 32'h400);
      chk("jal", {imm, ctrl.sel_next_pc_alu_out, ctrl.sel_wb, ctrl.reg_wr_en}, {32'h800, 1'b1, 1'b0, 1'b1});
      cycle(2); out_ready = 0;
      send(32'h00500293, 32'h500); send(32'h00600313, 32'h504);
      in_valid = 1; in_instr = 32'h00700393; flush = 1;
      cycle(1); flush = 0; in_valid = 0;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      send(32'h00800413, 32'h600);
      in_valid = 1; in_instr = 32'h0; flush = 1;
      cycle(1); flush = 0; in_valid = 0; out_ready = 1;
      chk("flush_accept_drop", {out_valid, illegal_cnt}, {1'b0, 8'd4});
      out_ready = 0;
      send(32'h00900493, 32'h700);
      in_valid = 1; flush = 1; rst_n = 0;
      cycle(1); rst_n = 1; flush = 0; in_valid = 0;
      chk("rst_mid", {out_valid, in_ready, illegal_cnt, out_pc, imm, ctrl, illegal}, {1'b0, 1'b1, 8'd0, 32'd0, 32'd0, 15'd0, 1'b0});
      rnd = 1;
      for (int k = 0; k < 800; k++) begin
         send(rand_instr(), 32'h1000 + 4 * k);
         if ($urandom_range(0, 3) == 0) cycle($urandom_range(1, 3));
      end
      rnd = 0; cycle(1); flush = 0; out_ready = 1; cycle(6);
      chk("drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, flow-controlled successor to the combinational instruction decoder.
- Sits between fetch and execute. Accepts one RV32I instruction plus PC per valid/ready handshake and decodes all base opcode classes into register addresses, an immediate and a t_ctrl bundle.
- Presents the result one cycle later from an output register backed by a one-entry skid buffer, so full throughput holds under backpressure.
- Flags illegal encodings and keeps a saturating illegal-instruction counter.

Parameters:
- XLEN, 32: width of imm, in_pc and out_pc.
- CNT_W, 8: width of the illegal-instruction counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  drops all held entries (branch redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded entry presented.
- out_ready  in  1  execute consumes.
- out_pc  out  XLEN  registered PC.
- rs1, rs2, rd  out  5 each  bits [19:15], [24:20], [11:7].
- imm  out  XLEN  sign-extended immediate.
- ctrl  out  t_ctrl  control bundle (cpu_pkg).
- illegal  out  1  entry is an illegal instruction.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Reset (rst_n=0 at an edge):
  - out_valid=0, skid empty, illegal_cnt=0.
  - in_ready=1 from the first cycle after reset.
  - Payload outputs are 0, including ctrl; reset wins over every other input.
- Decode is combinational on in_instr. The result is captured into the output register or the skid entry on accept (in_valid & in_ready).
- Latency: exactly 1 cycle from accept to out_valid when the output register is free.
- Handshake:
  - in_ready = ~skid_valid.
  - On out_valid & out_ready: the skid entry, if present, moves to the output register; otherwise a same-cycle accept moves there; otherwise out_valid clears.
  - Accept while out_valid & ~out_ready: the entry goes to skid.
  - Payload must not change while out_valid & ~out_ready.
- Flush:
  - Next cycle: out_valid=0 and skid empty.
  - An accept in the flush cycle is discarded.
  - illegal_cnt is not incremented for discarded instructions.
- Immediates:
  - I (0010011, 0000011, 1100111): {sext inst[31:20]}.
  - S (0100011): {inst[31:25], inst[11:7]}.
  - B (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U (0110111, 0010111): {inst[31:12], 12'b0}.
  - J (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R: 0.
  - All immediates are sign-extended to XLEN.
- ctrl defaults: alu_op=ALU_ADD, all selects 0, reg_wr_en=0, mem_byt_en=0000, mem_wr_en=0, sel_wb=1.
- ctrl per opcode:
  - R: reg_wr_en=1. alu_op from funct3/funct7: ADD, SUB (f7=0100000), SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - OP-IMM: as R plus sel_alu_imm=1. SUB is not allowed. SRAI is selected by inst[30].
  - LOAD: sel_alu_imm=1, reg_wr_en=1, sel_dmem_wb=1. mem_byt_en is 0001, 0011 or 1111 for funct3[1:0] of 00, 01 or 10.
  - STORE: sel_alu_imm=1, mem_wr_en=1, mem_byt_en as for LOAD.
  - BRANCH: sel_alu_pc=1, sel_alu_imm=1. Branch resolution happens downstream.
  - JAL: sel_alu_pc=1, sel_alu_imm=1, sel_next_pc_alu_out=1, reg_wr_en=1, sel_wb=0 (write PC+4).
  - JALR: as JAL but sel_alu_pc=0.
  - LUI: sel_alu_imm=1, reg_wr_en=1, rs1 forced to 0.
  - AUIPC: sel_alu_pc=1, sel_alu_imm=1, reg_wr_en=1.
- Illegal conditions:
  - Unknown opcode, or inst[1:0]≠11.
  - Bad funct7 on R, SLLI or SRxI.
  - funct3 of 011 or above on STORE.
  - funct3 of 011, 110 or 111 on LOAD.
  - funct3 of 010 or 011 on BRANCH.
- On an illegal instruction: illegal=1 and ctrl is forced to defaults (no write, no memory access).
- illegal_cnt increments on accept of an illegal, non-flushed instruction and saturates at all-ones.
- rd=0 writes are left to the register file; the decoder does not clear reg_wr_en for them.

Test Plan:
- Reset then ADDI x1,x0,-1 (0xFFF00093), out_ready=1 → next cycle out_valid=1, rd=1, imm=0xFFFFFFFF, sel_alu_imm=1, reg_wr_en=1, alu_op=ALU_ADD.
- SUB x3,x1,x2 (0x402081B3) then SW x2,8(x1) (0x0020A423):
  - SUB → alu_op=ALU_SUB.
  - SW → imm=8, mem_wr_en=1, mem_byt_en=1111, reg_wr_en=0, illegal=0.
- Backpressure, with out_ready=0 and three instructions offered back-to-back:
  - First instruction lands in out, second in skid, then in_ready=0 and the third is held at the input.
  - Raising out_ready drains them in order with no loss or duplication.
- Illegal 0x00000000 accepted 3 times, then 0xFFFFFFFF → illegal=1 each time, ctrl at defaults, illegal_cnt=4. Repeat with CNT_W=2 → saturates at 3.
- JAL x1,+2048 (0x001000EF) → imm=0x00000800, sel_next_pc_alu_out=1, sel_wb=0, reg_wr_en=1.
- Edge cases:
  - Flush with skid full and an accept in the same cycle → next cycle out_valid=0 and in_ready=1.
  - rst_n=0 mid-stream → all outputs at reset values on the next edge.
